key_epoch_scheduler: RTL and testbench
======================================

Name: key_epoch_scheduler

Overview:
- Schedules key changes for the 2FA key fob from the 1 MHz system clock.
- Generates single-cycle enable strobes instead of derived clocks: a display-refresh tick, a 1 s tick, and a period-expiry event.
- Runs a req/ack handshake with the key generator, maintains a key epoch counter and a seconds-remaining countdown for the display.
- Sits between the RTC timebase and the key generator / display driver.

Parameters:
- CLK_FREQ_HZ, 1000000, sys_clk frequency.
- REFRESH_HZ, 500, refresh_tick rate; CLK_FREQ_HZ/REFRESH_HZ must be an integer ≥2.
- KEYCHANGE_PERIOD, 5, key period in seconds, 1..255.
- ACK_TIMEOUT, 64, sys_clk cycles to wait for key_ack, ≥1.
- EPOCH_W, 16, key_epoch width.

Ports:
- sys_clk  in  1  system clock, 1 MHz.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  timebase run; low freezes both prescalers and secs_left.
- resync  in  1  single-cycle pulse: restart period now and force a key change.
- refresh_tick  out  1  one-cycle strobe at REFRESH_HZ.
- sec_tick  out  1  one-cycle strobe each second.
- key_req  out  1  key-change request to the generator.
- key_ack  in  1  generator acknowledge, sampled while key_req=1.
- key_epoch  out  EPOCH_W  count of completed key changes.
- secs_left  out  8  seconds until the next key change.
- timeout_err  out  1  sticky: ack timeout occurred.

Behaviour:
- Interface: one clock sys_clk; reset rst_n is asynchronous, active-low.
- Reset values: all counters 0; refresh_tick=0, sec_tick=0, key_req=0, key_epoch=0, timeout_err=0; secs_left=KEYCHANGE_PERIOD; state IDLE; pending=0.
- Refresh prescaler: counts 0..CLK_FREQ_HZ/REFRESH_HZ-1 while enable=1.
  - refresh_tick is registered and high for exactly the one cycle after the terminal count.
- Second prescaler: same scheme with modulus CLK_FREQ_HZ, drives sec_tick.
- Countdown: on sec_tick, secs_left decrements.
  - When sec_tick occurs with secs_left==1, secs_left reloads to KEYCHANGE_PERIOD in the same cycle and a change event fires.
  - secs_left never shows 0.
- enable=0: prescalers and secs_left hold; no ticks are generated; an in-flight handshake still completes.
- States:
  - IDLE: on a change event, go to REQ.
  - REQ: assert key_req (registered, rises 1 cycle after the event), go to WAIT_ACK.
  - WAIT_ACK: key_req held high. On key_ack=1: key_epoch+1 (wraps all-ones→0), key_req low next cycle. Then go to REQ if pending=1 (clear pending), else IDLE.
- A change event during REQ or WAIT_ACK sets pending.
  - Pending is 1 bit; multiple overruns collapse into one extra request.
- key_ack outside WAIT_ACK is ignored.
- resync: clears both prescalers, reloads secs_left=KEYCHANGE_PERIOD, and raises a change event.
  - resync in the same cycle as a natural expiry yields one event only.
  - resync while enable=0 still takes effect.
- Reset mid-handshake: key_req drops asynchronously; the epoch does not increment.

Optional Feature:
- Macro KEY_ACK_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in WAIT_ACK.
  - After ACK_TIMEOUT cycles without ack: timeout_err sets (sticky until reset), key_req drops for 1 cycle, state returns to REQ (retry); key_epoch is unchanged.
- Undefined:
  - WAIT_ACK waits indefinitely.
  - timeout_err is tied 0 and no watchdog logic exists.

Decomposition:
- Package key_sched_pkg holds:
  - state enum (IDLE, REQ, WAIT_ACK);
  - derived constants REFRESH_DIV = CLK_FREQ_HZ/REFRESH_HZ, plus counter widths via $clog2;
  - the secs_left width of 8.
- Sub-module tick_prescaler (parameter DIV; ports sys_clk, rst_n, en, clr, tick) is instantiated twice: refresh and second.

Test Plan (CLK_FREQ_HZ=100, REFRESH_HZ=10, KEYCHANGE_PERIOD=3, ACK_TIMEOUT=8, ack responder with 2-cycle latency):
- Release reset, enable=1 → refresh_tick every 10 cycles; sec_tick at cycles 100, 200, 300; secs_left 3→2→1→3; key_req rises at cycle 301; key_epoch=1 after ack.
- Run 0x10000 forced changes via resync (EPOCH_W=16) → key_epoch wraps 0xFFFF→0x0000.
- resync at cycle 150 → secs_left=3, prescalers cleared, key_req 1 cycle later; next natural sec_tick at cycle 250.
- Ack withheld; resync while in WAIT_ACK, then ack → exactly two increments total, second key_req follows without any sec_tick.
- enable low at cycle 50 for 200 cycles → no ticks, secs_left frozen at 3; first sec_tick at cycle 300.
- With KEY_ACK_TIMEOUT_EN, ack never given → timeout_err=1 after 8 WAIT_ACK cycles, key_req 1-cycle gap then re-asserted; key_epoch stays 0. Without the macro, key_req stays high indefinitely and timeout_err=0.

Source files
------------

// File: rtl/key_sched_pkg.sv
// -----------------------------------------------------------------------------
// key_sched_pkg
// Shared types and derived constants for the key-epoch scheduler.
//   state_e        : handshake FSM states (IDLE, REQ, WAIT_ACK)
//   SECS_W         : width of the seconds-remaining display value
//   DEF_*          : default timebase figures for the 1 MHz key fob build
//   REFRESH_DIV    : refresh prescaler modulus for the default timebase
//   refresh_div()  : refresh prescaler modulus for any timebase
//   cnt_w()        : counter width able to hold 0..modulus-1 (at least 1 bit)
// -----------------------------------------------------------------------------
package key_sched_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_e;

    localparam int unsigned SECS_W          = 8;
    localparam int unsigned DEF_CLK_FREQ_HZ = 1_000_000;
    localparam int unsigned DEF_REFRESH_HZ  = 500;

    function automatic int unsigned refresh_div(input int unsigned clk_hz,
                                                input int unsigned refresh_hz);
        return clk_hz / refresh_hz;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned modulus);
        return (modulus > 1) ? $clog2(modulus) : 1;
    endfunction

    localparam int unsigned REFRESH_DIV   = refresh_div(DEF_CLK_FREQ_HZ, DEF_REFRESH_HZ);
    localparam int unsigned REFRESH_CNT_W = cnt_w(REFRESH_DIV);
    localparam int unsigned SEC_CNT_W     = cnt_w(DEF_CLK_FREQ_HZ);

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Modulo-DIV cycle counter producing a registered single-cycle enable strobe.
// The strobe is high for exactly the one cycle after the counter passes its
// terminal count (DIV-1). Counting only advances while en=1; clr restarts the
// count from zero and suppresses any strobe.
// Ports:
//   sys_clk : system clock
//   rst_n   : asynchronous active-low reset
//   en      : count enable
//   clr     : synchronous restart (wins over en)
//   tick    : one-cycle strobe every DIV enabled cycles
// -----------------------------------------------------------------------------
module tick_prescaler
    import key_sched_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned   CW   = cnt_w(DIV);
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            if (cnt_q == TERM) begin
                cnt_d  = '0;
                tick_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/key_epoch_scheduler.sv
// -----------------------------------------------------------------------------
// key_epoch_scheduler
// Schedules key changes for the 2FA key fob. Two prescalers derive a display
// refresh strobe and a 1 s strobe (enables, not clocks). A seconds countdown
// fires a change event on expiry; each event is turned into a req/ack
// handshake with the key generator, and every acknowledged change advances
// key_epoch.
//
// Optional feature (macro KEY_ACK_TIMEOUT_EN):
//   defined   : a watchdog bounds WAIT_ACK to ACK_TIMEOUT cycles; on expiry
//               timeout_err sets (sticky), key_req drops for one cycle and the
//               request is retried; key_epoch is not advanced.
//   undefined : WAIT_ACK waits indefinitely and timeout_err is tied low.
//
// Ports:
//   sys_clk      in  system clock
//   rst_n        in  asynchronous active-low reset
//   enable       in  timebase run; low freezes prescalers and secs_left
//   resync       in  pulse: restart the period now and force a key change
//   refresh_tick out one-cycle strobe at REFRESH_HZ
//   sec_tick     out one-cycle strobe each second
//   key_req      out key-change request to the generator
//   key_ack      in  generator acknowledge, honoured only in WAIT_ACK
//   key_epoch    out count of completed key changes (wraps)
//   secs_left    out seconds until next key change, never 0
//   timeout_err  out sticky acknowledge-timeout flag
// -----------------------------------------------------------------------------
module key_epoch_scheduler
    import key_sched_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = DEF_CLK_FREQ_HZ,
    parameter int unsigned REFRESH_HZ       = DEF_REFRESH_HZ,
    parameter int unsigned KEYCHANGE_PERIOD = 5,
    parameter int unsigned ACK_TIMEOUT      = 64,
    parameter int unsigned EPOCH_W          = 16
) (
    input  logic               sys_clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               resync,
    output logic               refresh_tick,
    output logic               sec_tick,
    output logic               key_req,
    input  logic               key_ack,
    output logic [EPOCH_W-1:0] key_epoch,
    output logic [SECS_W-1:0]  secs_left,
    output logic               timeout_err
);

    localparam int unsigned       R_DIV  = refresh_div(CLK_FREQ_HZ, REFRESH_HZ);
    localparam logic [SECS_W-1:0] PERIOD = SECS_W'(KEYCHANGE_PERIOD);

    // Elaboration-time legality checks on the configuration.
    if ((CLK_FREQ_HZ % REFRESH_HZ) != 0 || R_DIV < 2) begin : g_bad_refresh
        $error("key_epoch_scheduler: CLK_FREQ_HZ/REFRESH_HZ must be an integer >= 2");
    end
    if (KEYCHANGE_PERIOD < 1 || KEYCHANGE_PERIOD > 255) begin : g_bad_period
        $error("key_epoch_scheduler: KEYCHANGE_PERIOD must be 1..255");
    end
    if (ACK_TIMEOUT < 1) begin : g_bad_timeout
        $error("key_epoch_scheduler: ACK_TIMEOUT must be >= 1");
    end

    // ------------------------------------------------------------------
    // Timebase
    // ------------------------------------------------------------------
    tick_prescaler #(
        .DIV (R_DIV)
    ) u_refresh (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .en      (enable),
        .clr     (resync),
        .tick    (refresh_tick)
    );

    tick_prescaler #(
        .DIV (CLK_FREQ_HZ)
    ) u_second (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .en      (enable),
        .clr     (resync),
        .tick    (sec_tick)
    );

    // ------------------------------------------------------------------
    // Seconds countdown and change-event generation
    // ------------------------------------------------------------------
    logic [SECS_W-1:0] secs_q, secs_d;
    logic              sec_step;
    logic              expire;
    logic              change_evt;

    // A strobe already on the wire when enable drops is not consumed.
    assign sec_step   = enable & sec_tick;
    assign expire     = sec_step & (secs_q == SECS_W'(1));
    // OR-merge: a resync coinciding with natural expiry is a single event.
    assign change_evt = resync | expire;

    always_comb begin
        secs_d = secs_q;
        if (resync) begin
            secs_d = PERIOD;
        end else if (sec_step) begin
            // Reload in the same cycle as the last second so 0 is never shown.
            secs_d = (secs_q == SECS_W'(1)) ? PERIOD : (secs_q - 1'b1);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            secs_q <= PERIOD;
        end else begin
            secs_q <= secs_d;
        end
    end

    assign secs_left = secs_q;

    // ------------------------------------------------------------------
    // Optional acknowledge watchdog
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   wd_expired;

`ifdef KEY_ACK_TIMEOUT_EN
    localparam int unsigned   WD_W    = cnt_w(ACK_TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(ACK_TIMEOUT - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            err_q, err_d;

    // wd_q counts completed WAIT_ACK cycles; it restarts on every entry.
    assign wd_expired = (state_q == WAIT_ACK) && !key_ack && (wd_q == WD_LAST);

    always_comb begin
        wd_d  = '0;
        err_d = err_q | wd_expired;
        if (state_q == WAIT_ACK && !wd_expired) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= wd_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Request / acknowledge FSM
    // ------------------------------------------------------------------
    logic               pending_q, pending_d;
    logic               key_req_q, key_req_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        key_req_d = key_req_q;
        epoch_d   = epoch_q;
        unique case (state_q)
            IDLE: begin
                key_req_d = 1'b0;
                if (change_evt) begin
                    state_d   = REQ;
                    key_req_d = 1'b1;
                end
            end
            REQ: begin
                // After a retry or a queued request key_req is low here,
                // giving the generator a clean rising edge on WAIT_ACK entry.
                state_d   = WAIT_ACK;
                key_req_d = 1'b1;
                if (change_evt) begin
                    pending_d = 1'b1;
                end
            end
            WAIT_ACK: begin
                key_req_d = 1'b1;
                if (change_evt) begin
                    pending_d = 1'b1;
                end
                if (key_ack) begin
                    epoch_d   = epoch_q + 1'b1;
                    key_req_d = 1'b0;
                    // An event landing with the ack collapses into the queue.
                    if (pending_q || change_evt) begin
                        state_d   = REQ;
                        pending_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (wd_expired) begin
                    state_d   = REQ;
                    key_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                key_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= 1'b0;
            key_req_q <= 1'b0;
            epoch_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            key_req_q <= key_req_d;
            epoch_q   <= epoch_d;
        end
    end

    assign key_req   = key_req_q;
    assign key_epoch = epoch_q;

endmodule

// File: tb/tb_key_epoch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_key_epoch_scheduler
// Directed bench for key_epoch_scheduler with a scaled timebase
// (CLK_FREQ_HZ=100, REFRESH_HZ=10, KEYCHANGE_PERIOD=3, ACK_TIMEOUT=8).
// Cycle N means the state just after the N-th rising edge following reset
// release. The main instance uses a key generator model that acknowledges
// two cycles after key_req rises. Epoch wrap-around is exercised on a second
// instance with EPOCH_W=4 (16 forced changes) so the run stays short.
// -----------------------------------------------------------------------------
module tb_key_epoch_scheduler;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        resync;
    logic        refresh_tick;
    logic        sec_tick;
    logic        key_req;
    logic        key_ack;
    logic [15:0] key_epoch;
    logic [7:0]  secs_left;
    logic        timeout_err;

    logic        resync_w;
    logic        refresh_tick_w;
    logic        sec_tick_w;
    logic        key_req_w;
    logic        key_ack_w;
    logic [3:0]  key_epoch_w;
    logic [7:0]  secs_left_w;
    logic        timeout_err_w;

    logic        ack_en;
    logic        ack_force;
    logic        ack_resp;
    int          ack_cnt;
    int          cyc;
    int          n_tests;
    int          n_fail;

    key_epoch_scheduler #(
        .CLK_FREQ_HZ      (100),
        .REFRESH_HZ       (10),
        .KEYCHANGE_PERIOD (3),
        .ACK_TIMEOUT      (8),
        .EPOCH_W          (16)
    ) dut (
        .sys_clk      (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .resync       (resync),
        .refresh_tick (refresh_tick),
        .sec_tick     (sec_tick),
        .key_req      (key_req),
        .key_ack      (key_ack),
        .key_epoch    (key_epoch),
        .secs_left    (secs_left),
        .timeout_err  (timeout_err)
    );

    key_epoch_scheduler #(
        .CLK_FREQ_HZ      (100),
        .REFRESH_HZ       (10),
        .KEYCHANGE_PERIOD (3),
        .ACK_TIMEOUT      (8),
        .EPOCH_W          (4)
    ) dut_w (
        .sys_clk      (clk),
        .rst_n        (rst_n),
        .enable       (1'b0),
        .resync       (resync_w),
        .refresh_tick (refresh_tick_w),
        .sec_tick     (sec_tick_w),
        .key_req      (key_req_w),
        .key_ack      (key_ack_w),
        .key_epoch    (key_epoch_w),
        .secs_left    (secs_left_w),
        .timeout_err  (timeout_err_w)
    );

    // Generator for the wrap instance acknowledges as soon as it sees key_req.
    assign key_ack_w = key_req_w;
    assign key_ack   = ack_resp | ack_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Key generator model: ack two cycles after key_req rises, held until
    // key_req falls (the scheduler drops key_req right after the ack).
    always @(negedge clk) begin
        if (!rst_n || !key_req) begin
            ack_cnt  <= 0;
            ack_resp <= 1'b0;
        end else begin
            ack_cnt  <= ack_cnt + 1;
            ack_resp <= ack_en && ((ack_cnt + 1) >= 2);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        enable    = 1'b0;
        resync    = 1'b0;
        resync_w  = 1'b0;
        ack_en    = 1'b1;
        ack_force = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        enable    = 1'b0;
        resync    = 1'b0;
        resync_w  = 1'b0;
        ack_en    = 1'b1;
        ack_force = 1'b0;
        #12;

        // Reset values
        chk("rst_refresh_tick", 32'(refresh_tick), 32'd0);
        chk("rst_sec_tick",     32'(sec_tick),     32'd0);
        chk("rst_key_req",      32'(key_req),      32'd0);
        chk("rst_key_epoch",    32'(key_epoch),    32'd0);
        chk("rst_secs_left",    32'(secs_left),    32'd3);
        chk("rst_timeout_err",  32'(timeout_err),  32'd0);

        // Free-running period: ticks, countdown, natural key change
        do_reset();
        for (int c = 1; c <= 300; c++) begin
            tick();
            chk("p1_refresh_tick", 32'(refresh_tick), 32'((c % 10) == 0));
            chk("p1_sec_tick",     32'(sec_tick),     32'((c % 100) == 0));
            chk("p1_secs_left",    32'(secs_left),    (c <= 100) ? 32'd3 : (c <= 200) ? 32'd2 : 32'd1);
            chk("p1_key_req_idle", 32'(key_req),      32'd0);
        end
        tick();  // 301
        chk("p1_secs_reload",  32'(secs_left), 32'd3);
        chk("p1_req_rise",     32'(key_req),   32'd1);
        chk("p1_epoch_pre",    32'(key_epoch), 32'd0);
        tick();  // 302
        chk("p1_req_hold",     32'(key_req),   32'd1);
        tick();  // 303
        chk("p1_epoch_after",  32'(key_epoch), 32'd1);
        chk("p1_req_fall",     32'(key_req),   32'd0);

        // Epoch wrap on the narrow instance, forced by resync with enable=0
        for (int i = 0; i < 16; i++) begin
            resync_w = 1'b1;
            tick();
            resync_w = 1'b0;
            tick();
            tick();
            chk("wrap_epoch", 32'(key_epoch_w), 32'((i + 1) % 16));
        end
        chk("wrap_req_idle", 32'(key_req_w), 32'd0);

        // resync at cycle 150
        do_reset();
        run_to(149);
        chk("p2_secs_149", 32'(secs_left), 32'd2);
        resync = 1'b1;
        tick();  // 150
        resync = 1'b0;
        chk("p2_secs_reload",   32'(secs_left),    32'd3);
        chk("p2_req_rise",      32'(key_req),      32'd1);
        chk("p2_refresh_clear", 32'(refresh_tick), 32'd0);
        tick();
        tick();  // 152
        chk("p2_epoch", 32'(key_epoch), 32'd1);
        run_to(159);
        chk("p2_refresh_159", 32'(refresh_tick), 32'd0);
        tick();  // 160
        chk("p2_refresh_160", 32'(refresh_tick), 32'd1);
        run_to(200);
        chk("p2_no_sec_200", 32'(sec_tick), 32'd0);
        run_to(249);
        chk("p2_sec_249",  32'(sec_tick),  32'd0);
        chk("p2_secs_249", 32'(secs_left), 32'd3);
        tick();  // 250
        chk("p2_sec_250",  32'(sec_tick),  32'd1);
        tick();  // 251
        chk("p2_secs_251", 32'(secs_left), 32'd2);

        // Ack withheld, resync while in WAIT_ACK, then ack: two increments
        ack_en = 1'b0;
        resync = 1'b1;
        tick();  // t0
        resync = 1'b0;
        chk("p3_req_t0", 32'(key_req), 32'd1);
        tick();
        tick();  // t0+2, waiting for ack
        resync = 1'b1;
        tick();  // t0+3, queued
        resync = 1'b0;
        ack_en = 1'b1;
        chk("p3_epoch_t3", 32'(key_epoch), 32'd1);
        chk("p3_req_t3",   32'(key_req),   32'd1);
        tick();  // t0+4
        chk("p3_epoch_t4", 32'(key_epoch), 32'd2);
        chk("p3_req_gap",  32'(key_req),   32'd0);
        tick();  // t0+5
        chk("p3_req_again", 32'(key_req),  32'd1);
        chk("p3_no_sec",    32'(sec_tick), 32'd0);
        tick();
        tick();  // t0+7
        chk("p3_epoch_t7", 32'(key_epoch), 32'd3);
        chk("p3_req_t7",   32'(key_req),   32'd0);
        tick();
        chk("p3_req_t8",   32'(key_req),   32'd0);
        ack_force = 1'b1;
        tick();
        tick();
        chk("p3_stray_ack_epoch", 32'(key_epoch), 32'd3);
        chk("p3_stray_ack_req",   32'(key_req),   32'd0);
        ack_force = 1'b0;

        // enable low from cycle 50 for 200 cycles
        do_reset();
        run_to(49);
        enable = 1'b0;
        for (int c = 50; c < 250; c++) begin
            tick();
            chk("p4_frz_refresh", 32'(refresh_tick), 32'd0);
            chk("p4_frz_sec",     32'(sec_tick),     32'd0);
            chk("p4_frz_secs",    32'(secs_left),    32'd3);
        end
        enable = 1'b1;
        tick();  // 250
        chk("p4_refresh_250", 32'(refresh_tick), 32'd1);
        run_to(299);
        chk("p4_sec_299",  32'(sec_tick),  32'd0);
        tick();  // 300
        chk("p4_sec_300",  32'(sec_tick),  32'd1);
        chk("p4_secs_300", 32'(secs_left), 32'd3);
        tick();  // 301
        chk("p4_secs_301", 32'(secs_left), 32'd2);

        // Ack never given
        do_reset();
        ack_en = 1'b0;
        resync = 1'b1;
        tick();  // t0
        resync = 1'b0;
        chk("p5_req_t0", 32'(key_req), 32'd1);
`ifdef KEY_ACK_TIMEOUT_EN
        repeat (8) tick();  // t0+8
        chk("p5_req_t8", 32'(key_req),     32'd1);
        chk("p5_err_t8", 32'(timeout_err), 32'd0);
        tick();  // t0+9
        chk("p5_req_gap",   32'(key_req),     32'd0);
        chk("p5_err_set",   32'(timeout_err), 32'd1);
        chk("p5_epoch_t9",  32'(key_epoch),   32'd0);
        tick();  // t0+10
        chk("p5_req_retry", 32'(key_req),     32'd1);
        chk("p5_err_stick", 32'(timeout_err), 32'd1);
`else
        for (int c = 0; c < 40; c++) begin
            tick();
            chk("p5_req_held", 32'(key_req),     32'd1);
            chk("p5_err_zero", 32'(timeout_err), 32'd0);
        end
        chk("p5_epoch_held", 32'(key_epoch), 32'd0);
`endif

        // Asynchronous reset in the middle of a handshake
        #2;
        rst_n = 1'b0;
        #1;
        chk("p6_req_async_drop", 32'(key_req),     32'd0);
        chk("p6_epoch",          32'(key_epoch),   32'd0);
        chk("p6_secs",           32'(secs_left),   32'd3);
        chk("p6_err",            32'(timeout_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
